dcache_assoc: RTL and testbench

- Parametrised, set-associative, write-back, write-allocate data cache for the MEM/WB stage of the RV32 pipeline.
- Successor to the fixed direct-mapped data cache: way count, set count and line size are parameters, and it adds a replacement policy and dirty-line write-back.
- Raises `miss` to the hazard unit, which stalls the pipeline, while it refills a line from the word-serial main-memory port.

---
 rtl/dcache_assoc.sv | 205 ++++++++++++++++++++
 tb/tb_dcache_assoc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_assoc.sv
// Set-associative, write-back, write-allocate data cache with word-serial line refill/eviction.
// Replacement is FIFO per set; define DCACHE_LRU_EN for true per-set LRU instead.
module dcache_assoc #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 2,
    parameter int WAY_CNT       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [3:0]  wr_be,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_gnt
);
    localparam int TAG_LEN    = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int LINE_WORDS = 2 ** LINE_ADDR_LEN;
    localparam int SET_CNT    = 2 ** SET_ADDR_LEN;
    localparam int WAY_W      = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;

    typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;

    state_t                   r_state, w_state_next;
    logic [LINE_ADDR_LEN-1:0] r_beat;
    logic [WAY_W-1:0]         r_victim;
    logic [WAY_CNT-1:0]       r_valid [SET_CNT];
    logic [WAY_CNT-1:0]       r_dirty [SET_CNT];
    logic [TAG_LEN-1:0]       r_tag   [SET_CNT][WAY_CNT];
    logic [31:0]              r_data  [SET_CNT][WAY_CNT][LINE_WORDS];
    logic [31:0]              r_buf   [LINE_WORDS];

    logic [TAG_LEN-1:0]       w_tag;
    logic [SET_ADDR_LEN-1:0]  w_set;
    logic [LINE_ADDR_LEN-1:0] w_word;
    logic                     w_req, w_hit, w_store_hit, w_last_beat;
    logic [WAY_CNT-1:0]       w_way_hit;
    logic [31:0]              w_way_rd [WAY_CNT];
    logic [WAY_W-1:0]         w_hit_way, w_victim, w_policy_way;
    logic                     w_unused_addr;

    assign w_word        = addr[LINE_ADDR_LEN+1:2];
    assign w_set         = addr[SET_ADDR_LEN+LINE_ADDR_LEN+1:LINE_ADDR_LEN+2];
    assign w_tag         = addr[31:SET_ADDR_LEN+LINE_ADDR_LEN+2];
    assign w_unused_addr = ^addr[1:0];
    assign w_req         = rd_req | wr_req;
    assign w_hit         = |w_way_hit;
    assign w_store_hit   = (r_state == IDLE) && wr_req && w_hit;
    assign w_last_beat   = (r_beat == LINE_ADDR_LEN'(LINE_WORDS - 1));
    assign miss          = w_req && (!w_hit || r_state != IDLE);

    for (genvar gi = 0; gi < WAY_CNT; gi++) begin : g_way
        assign w_way_hit[gi] = r_valid[w_set][gi] && (r_tag[w_set][gi] == w_tag);
        assign w_way_rd[gi]  = w_way_hit[gi] ? r_data[w_set][gi][w_word] : 32'd0;
    end

    // At most one way hits, so OR-merging the masked way words yields the hit word (or 0).
    always_comb begin
        rd_data   = '0;
        w_hit_way = '0;
        for (int i = 0; i < WAY_CNT; i++) begin
            rd_data = rd_data | w_way_rd[i];
            if (w_way_hit[i]) w_hit_way = WAY_W'(i);
        end
    end

    always_comb begin
        w_victim = w_policy_way;
        for (int i = WAY_CNT - 1; i >= 0; i--) begin
            if (!r_valid[w_set][i]) w_victim = WAY_W'(i);
        end
    end

`ifdef DCACHE_LRU_EN
    logic [WAY_W-1:0] r_age [SET_CNT][WAY_CNT];
    logic             w_lru_touch;
    logic [WAY_W-1:0] w_lru_way, w_lru_ref;

    always_comb begin
        w_policy_way = '0;
        for (int i = 0; i < WAY_CNT; i++) begin
            if (r_age[w_set][i] == WAY_W'(WAY_CNT - 1)) w_policy_way = WAY_W'(i);
        end
    end

    // An install is treated as touching the oldest age so that ways filled from
    // the all-zero reset state settle into a proper age permutation.
    always_comb begin
        w_lru_touch = 1'b0;
        w_lru_way   = w_hit_way;
        w_lru_ref   = r_age[w_set][w_hit_way];
        if (r_state == SWAP_IN_OK) begin
            w_lru_touch = 1'b1;
            w_lru_way   = r_victim;
            w_lru_ref   = WAY_W'(WAY_CNT - 1);
        end else if (r_state == IDLE && w_req && w_hit) begin
            w_lru_touch = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SET_CNT; s++)
                for (int w = 0; w < WAY_CNT; w++) r_age[s][w] <= '0;
        end else if (w_lru_touch) begin
            for (int w = 0; w < WAY_CNT; w++) begin
                if (WAY_W'(w) == w_lru_way)          r_age[w_set][w] <= '0;
                else if (r_age[w_set][w] < w_lru_ref) r_age[w_set][w] <= r_age[w_set][w] + WAY_W'(1);
            end
        end
    end
`else
    logic [WAY_W-1:0] r_fifo [SET_CNT];

    assign w_policy_way = r_fifo[w_set];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SET_CNT; s++) r_fifo[s] <= '0;
        end else if (r_state == SWAP_IN_OK) begin
            r_fifo[w_set] <= (r_fifo[w_set] == WAY_W'(WAY_CNT - 1)) ? '0 : r_fifo[w_set] + WAY_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_req && !w_hit)
                      w_state_next = (r_valid[w_set][w_victim] && r_dirty[w_set][w_victim]) ? SWAP_OUT : SWAP_IN;
            SWAP_OUT: if (mem_gnt && w_last_beat) w_state_next = SWAP_IN;
            SWAP_IN:  if (mem_gnt && w_last_beat) w_state_next = SWAP_IN_OK;
            default:  w_state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            SWAP_OUT: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_tag[w_set][r_victim], w_set, r_beat, 2'b00};
                mem_wdata = r_data[w_set][r_victim][r_beat];
            end
            SWAP_IN: begin
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_set, r_beat, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat   <= '0;
            r_victim <= '0;
        end else begin
            if (r_state == IDLE && w_req && !w_hit) r_victim <= w_victim;
            if ((r_state == SWAP_OUT || r_state == SWAP_IN) && mem_gnt) r_beat <= r_beat + LINE_ADDR_LEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SET_CNT; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else if (r_state == SWAP_IN_OK) begin
            r_valid[w_set][r_victim] <= 1'b1;
            r_dirty[w_set][r_victim] <= 1'b0;
        end else if (w_store_hit) begin
            r_dirty[w_set][w_hit_way] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == SWAP_IN && mem_gnt) r_buf[r_beat] <= mem_rdata;
        if (r_state == SWAP_IN_OK) begin
            r_tag[w_set][r_victim] <= w_tag;
            for (int w = 0; w < LINE_WORDS; w++) r_data[w_set][r_victim][w] <= r_buf[w];
        end else if (w_store_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) r_data[w_set][w_hit_way][w_word][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboard bench for dcache_assoc: stimulus pushes expected memory beats and load
// responses into a queue; a negedge monitor pops and compares as the DUT presents them.
module tb_dcache_assoc;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        rd_req, wr_req;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        miss, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_gnt = 1'b0;

    int total = 0;
    int bad   = 0;
    int stretch = 1;

    typedef struct { int kind; logic [31:0] a; logic [31:0] d; } exp_t;  // kind 0=load 1=read beat 2=write beat
    exp_t exp_q[$];

    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] gold_mem  [logic [31:0]];

    always #5 clk = ~clk;

    dcache_assoc dut (
        .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
        .wr_be(wr_be), .wr_data(wr_data), .rd_data(rd_data), .miss(miss),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_gnt(mem_gnt)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] gold(input logic [31:0] a);
        if (gold_mem.exists(a)) return gold_mem[a];
        return pat(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, want);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic push_refill(input logic [31:0] base);
        for (int i = 0; i < 8; i++) exp_q.push_back('{1, base + 32'(4*i), 32'd0});
    endtask

    task automatic push_wb(input logic [31:0] base);
        for (int i = 0; i < 8; i++) exp_q.push_back('{2, base + 32'(4*i), gold(base + 32'(4*i))});
    endtask

    task automatic push_load(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{0, a, d});
    endtask

    // Hold the request until miss drops; lat returns the number of cycles miss was high.
    task automatic access(input logic [31:0] a, input logic is_wr, input logic [3:0] be,
                          input logic [31:0] d, output int lat);
        int n = 0;
        @(posedge clk); #1;
        addr = a; rd_req = !is_wr; wr_req = is_wr; wr_be = be; wr_data = d;
        forever begin
            @(negedge clk);
            n++;
            if (!miss) break;
            if (n > 300) begin
                total++; bad++;
                $display("FAIL access_timeout: got miss still high after %0d cycles at addr=%h want miss=0", n, a);
                break;
            end
        end
        @(posedge clk); #1;
        rd_req = 1'b0; wr_req = 1'b0;
        lat = n - 1;
    endtask

    task automatic do_load(input logic [31:0] a, output int lat);
        access(a, 1'b0, 4'h0, 32'd0, lat);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, output int lat);
        logic [31:0] g;
        g = gold(a);
        for (int b = 0; b < 4; b++) if (be[b]) g[b*8 +: 8] = d[b*8 +: 8];
        gold_mem[a] = g;
        access(a, 1'b1, be, d, lat);
    endtask

    // Word-serial memory: grants every 'stretch'-th cycle that mem_req is held.
    initial begin
        int wait_cnt = 0;
        forever begin
            @(posedge clk); #2;
            mem_gnt = 1'b0;
            if (mem_req) begin
                wait_cnt++;
                if (wait_cnt >= stretch) begin
                    wait_cnt = 0;
                    mem_gnt  = 1'b1;
                    if (mem_we) mem_store[mem_addr] = mem_wdata;
                    else        mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : pat(mem_addr);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_req && mem_gnt) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat: got we=%0d addr=%h want no traffic", mem_we, mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_kind", mem_we ? 32'd2 : 32'd1, 32'(e.kind));
                    chk("beat_addr", mem_addr, e.a);
                    if (e.kind == 2) chk("beat_wdata", mem_wdata, e.d);
                end
            end else if (rd_req && !wr_req && !miss) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_load: got rd_data=%h addr=%h want none", rd_data, addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("load_kind", 32'd0, 32'(e.kind));
                    chk("rd_data", rd_data, e.d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int found;
        rst = 1'b1; addr = '0; rd_req = 1'b0; wr_req = 1'b0; wr_be = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_miss", 32'(miss), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Cold miss, then a same-line hit, then a partial store merged into the line.
        push_refill(32'h40); push_load(32'h40, gold(32'h40));
        do_load(32'h40, lat);          chk("lat_clean_miss", lat, 10);
        push_load(32'h44, gold(32'h44));
        do_load(32'h44, lat);          chk("lat_hit", lat, 0);
        do_store(32'h40, 4'b0011, 32'hDEAD_BEEF, lat); chk("lat_store_hit", lat, 0);
        push_load(32'h40, 32'hA5A5_BEEF);
        do_load(32'h40, lat);          chk("lat_load_after_store", lat, 0);

        // Fill set 0 with tags 1..4, dirty tag 1, then tag 5 evicts and writes back tag 1.
        push_refill(32'h80); push_load(32'h80, gold(32'h80));
        do_load(32'h80, lat);
        do_store(32'h84, 4'hF, 32'h1234_5678, lat); chk("lat_store_tag1", lat, 0);
        for (int t = 2; t <= 4; t++) begin
            push_refill(32'(t << 7)); push_load(32'(t << 7), gold(32'(t << 7)));
            do_load(32'(t << 7), lat);
        end
        push_wb(32'h80); push_refill(32'h280); push_load(32'h280, gold(32'h280));
        do_load(32'h280, lat);         chk("lat_dirty_miss", lat, 18);

        // Re-read tag 2, then tag 6: FIFO evicts tag 2, LRU evicts tag 3; both clean.
        push_load(32'h100, gold(32'h100));
        do_load(32'h100, lat);         chk("lat_reread_tag2", lat, 0);
        push_refill(32'h300); push_load(32'h304, gold(32'h304));
        do_load(32'h304, lat);         chk("lat_tag6_clean", lat, 10);
`ifdef DCACHE_LRU_EN
        push_load(32'h104, gold(32'h104));
        do_load(32'h104, lat);         chk("lat_tag2_kept", lat, 0);
`else
        push_refill(32'h100); push_load(32'h104, gold(32'h104));
        do_load(32'h104, lat);         chk("lat_tag2_evicted", lat, 10);
`endif

        // Slow memory: one grant every third cycle.
        stretch = 3;
        push_refill(32'h20); push_load(32'h20, gold(32'h20));
        do_load(32'h20, lat);          chk("lat_stretch", lat, 26);
        stretch = 1;
        push_load(32'h3C, gold(32'h3C));
        do_load(32'h3C, lat);          chk("lat_last_beat_hit", lat, 0);

        // Reset while beat 3 of a refill is on the bus.
        push_refill(32'h60);
        for (int i = 0; i < 4; i++) void'(exp_q.pop_back());
        @(posedge clk); #1;
        addr = 32'h60; rd_req = 1'b1;
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (mem_req && mem_addr == 32'h6C) begin found = 1; break; end
        end
        chk("beat3_seen", 32'(found), 32'd1);
        rst = 1'b1; rd_req = 1'b0;
        @(posedge clk); #3;
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_miss", 32'(miss), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        push_refill(32'h40); push_load(32'h48, 32'hA5A5_0048);
        do_load(32'h48, lat);          chk("lat_after_reset", lat, 10);

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
